dequantize_stream_unit: RTL and testbench

DEQUANTIZE_STREAM_UNIT -- requirements
Module: dequantize_stream_unit

---
 rtl/dequantize_stream_unit.sv | 129 ++++++++++++
 tb/tb_dequantize_stream_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantize_stream_unit.sv
// Three-stage int8 -> int32 dequantize pipeline: zero-point subtract, Q31 multiply,
// round/shift/saturate. A single global stall (advance) freezes every stage together.
module dequantize_stream_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_q,
  input  logic        choose_zero_point,
  input  logic [31:0] quant_mult,
  input  logic [5:0]  shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_acc,
  output logic        out_sat,
  output logic        sat_sticky,
  input  logic        clear_sat
);

  // Handshake: a beat moves on a rising edge when valid && ready are both high.
  // in_ready mirrors advance, so the whole pipe moves or holds as one unit and
  // streams at one beat per cycle while out_ready stays high.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- S1: zero-point subtract and shift decode ----------------
  logic [9:0]  zp_offset;
  logic [9:0]  diff_c;
  logic [5:0]  rshift_c;

  always_comb begin
    // Subtracting a negative zero point is adding its magnitude.
    zp_offset = choose_zero_point ? 10'd16 : 10'd128;
    diff_c    = {{2{in_q[7]}}, in_q} + zp_offset;
    // 31 + shift in 6-bit modular arithmetic; shift = -32 would wrap to 63,
    // so it is clamped to -31 (R = 0).
    if (shift == 6'b100000) begin
      rshift_c = 6'd0;
    end else begin
      rshift_c = 6'd31 + shift;
    end
  end

  logic        s1_valid;
  logic [9:0]  s1_diff;
  logic [31:0] s1_mult;
  logic [5:0]  s1_rshift;

  // ---------------- S2: signed 10x32 multiply ----------------
  logic signed [63:0] prod_c;

  always_comb begin
    prod_c = $signed({{54{s1_diff[9]}}, s1_diff}) * $signed({{32{s1_mult[31]}}, s1_mult});
  end

  logic               s2_valid;
  logic signed [63:0] s2_prod;
  logic [5:0]         s2_rshift;

  // ---------------- S3: round half up, arithmetic shift, saturate ----------------
  logic [63:0]        round_term_c;
  logic signed [63:0] sum_c;
  logic signed [63:0] shifted_c;
  logic               sat_c;
  logic [31:0]        acc_c;

  always_comb begin
    round_term_c = 64'd0;
    if (s2_rshift != 6'd0) begin
      round_term_c = 64'd1 << (s2_rshift - 6'd1);
    end
    // |prod| < 2^40 and the rounding term is at most 2^61, so the sum cannot wrap.
    sum_c     = s2_prod + $signed(round_term_c);
    shifted_c = sum_c >>> s2_rshift;
    // In range exactly when bits 63..31 are all copies of the sign bit.
    sat_c     = !((&shifted_c[63:31]) || !(|shifted_c[63:31]));
    if (sat_c) begin
      acc_c = shifted_c[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      acc_c = shifted_c[31:0];
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_mult   <= '0;
      s1_rshift <= '0;
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_rshift <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff   <= diff_c;
        s1_mult   <= quant_mult;
        s1_rshift <= rshift_c;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod   <= prod_c;
        s2_rshift <= s1_rshift;
      end
      out_valid <= s2_valid;
      out_sat   <= s2_valid && sat_c;
      if (s2_valid) begin
        out_acc <= acc_c;
      end
    end
  end

  // Clear wins over a set arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_sticky <= 1'b0;
    end else if (clear_sat) begin
      sat_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_sat) begin
      sat_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dequantize_stream_unit.sv
// Bench for dequantize_stream_unit: directed corner beats, a stalled stream,
// reset with beats in flight, then randomized traffic against an arithmetic model.
module tb_dequantize_stream_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_q;
  logic        choose_zero_point;
  logic [31:0] quant_mult;
  logic [5:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic        out_sat;
  logic        sat_sticky;
  logic        clear_sat;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];
  bit exp_sticky = 1'b0;
  bit rand_done  = 1'b0;

  dequantize_stream_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_q              (in_q),
    .choose_zero_point (choose_zero_point),
    .quant_mult        (quant_mult),
    .shift             (shift),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_acc           (out_acc),
    .out_sat           (out_sat),
    .sat_sticky        (sat_sticky),
    .clear_sat         (clear_sat)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: diff * mult / 2^R, rounded half toward +inf, clamped to int32.
  function automatic logic [32:0] model(input logic [7:0] q, input logic z,
                                        input logic [31:0] m, input logic [5:0] s);
    longint diff, prod, res, one;
    int sh, r;
    diff = longint'($signed(q)) - (z ? -16 : -128);
    prod = diff * longint'($signed(m));
    sh   = int'($signed(s));
    if (sh == -32) sh = -31;
    r    = 31 + sh;
    one  = 1;
    if (r == 0) res = prod;
    else        res = (prod + (one <<< (r - 1))) >>> r;
    if (res > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (res < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, res[31:0]};
  endfunction

  // Scoreboard: every valid output cycle must show the oldest pending beat.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_when_idle", out_valid, 0);
      end else begin
        check("out_beat", {out_sat, out_acc}, exp_q[0]);
        if (out_ready) begin
          if (exp_q[0][32]) exp_sticky = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a beat and returns #1 after the edge that accepts it; in_valid stays high.
  task automatic send_beat(input logic [7:0] q, input logic z, input logic [31:0] m,
                           input logic [5:0] s, input logic [32:0] e);
    bit done = 1'b0;
    in_q = q; choose_zero_point = z; quant_mult = m; shift = s; in_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", in_ready, 1);
  endtask

  task automatic directed(input string tag, input logic [7:0] q, input logic z,
                          input logic [31:0] m, input logic [5:0] s, input logic [32:0] e);
    send_beat(q, z, m, s, e);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat3"}, out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_sat = 1'b0;
    in_q = '0; choose_zero_point = 1'b0; quant_mult = '0; shift = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_acc", out_acc, 0);
    check("rst_sticky", sat_sticky, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    directed("zero", 8'd0, 1'b0, 32'h4000_0000, 6'd0, {1'b0, 32'd64});
    directed("round_up", 8'd127, 1'b0, 32'h4000_0000, 6'd0, {1'b0, 32'd128});
    directed("neg", 8'h80, 1'b1, 32'h4000_0000, 6'd1, {1'b0, 32'hFFFF_FFE4});
    check("sticky_quiet", sat_sticky, 0);
    directed("sat_r0", 8'd127, 1'b0, 32'h7FFF_FFFF, 6'b100001, {1'b1, 32'h7FFF_FFFF});
    check("sticky_set", sat_sticky, 1);
    clear_sat = 1'b1;
    @(posedge clk); #1;
    clear_sat = 1'b0;
    check("sticky_clear", sat_sticky, 0);
    directed("mult_zero", 8'd77, 1'b1, 32'd0, 6'd5, {1'b0, 32'd0});

    // Stream 1..8 with a 5-cycle downstream stall in the middle.
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send_beat(8'(i), 1'b0, 32'h4000_0000, 6'd0, model(8'(i), 1'b0, 32'h4000_0000, 6'd0));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          #1;
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("stream_drain");

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      send_beat(8'(10 * i), 1'b0, 32'h4000_0000, 6'd0, model(8'(10 * i), 1'b0, 32'h4000_0000, 6'd0));
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_acc", out_acc, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end
    directed("post_rst", 8'd0, 1'b0, 32'h4000_0000, 6'd0, {1'b0, 32'd64});

    // Randomized traffic with random gaps and random backpressure.
    clear_sat = 1'b1;
    @(posedge clk); #1;
    clear_sat = 1'b0;
    exp_sticky = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [7:0]  q;
          logic        z;
          logic [31:0] m;
          logic [5:0]  s;
          q = 8'($urandom);
          z = 1'($urandom);
          s = 6'($urandom_range(0, 63));
          case ($urandom_range(0, 4))
            0: m = $urandom;
            1: m = 32'($urandom_range(0, 65535));
            2: m = 32'd0;
            3: m = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: m = 32'h4000_0000 + 32'($urandom_range(0, 1023));
          endcase
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_beat(q, z, m, s, model(q, z, m, s));
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !(rand_done && exp_q.size() == 0); c++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("random_drain");
    @(posedge clk); #1;
    check("random_sticky", sat_sticky, exp_sticky);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
